cnn_layer_accel_octo_datain_router: RTL and testbench

- Upstream feeder for the octo BRAM controller: takes one generic input word stream and splits each map into a sequencer phase and a pixel phase.
- Drives the controller's datain_valid, seq_datain_tag and pixel_datain_tag, and consumes its registered seq_datain_rdy / pixel_datain_rdy.
- Issues the one-cycle new_map pulse that starts the controller, then tracks word counts to frame every map.

---
 rtl/cnn_layer_accel_octo_datain_router_pkg.sv | 17 +
 rtl/cnn_layer_accel_octo_datain_router_if.sv | 42 ++++
 rtl/cnn_layer_accel_skid_fifo2.sv | 50 +++++
 rtl/cnn_layer_accel_octo_datain_router.sv | 123 ++++++++++++
 tb/tb_cnn_layer_accel_octo_datain_router.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/cnn_layer_accel_octo_datain_router_pkg.sv
// Shared state encoding and default widths for the octo datain router.
// The router FSM is one-hot, so each state owns exactly one bit.
package cnn_layer_accel_router_pkg;

    localparam int C_DATA_WIDTH_DEF = 16;
    localparam int C_SEQ_CNT_W_DEF  = 12;
    localparam int C_PIX_CNT_W_DEF  = 18;

    typedef enum logic [4:0] {
        ST_IDLE    = 5'b00001,
        ST_NEW_MAP = 5'b00010,
        ST_SEQ     = 5'b00100,
        ST_PIX     = 5'b01000,
        ST_DONE    = 5'b10000
    } state_t;

endpackage

// File: rtl/cnn_layer_accel_octo_datain_router_if.sv
// Bundle of config, upstream stream and controller-facing signals for the router.
// master = feeder/controller side, slave = router.
interface cnn_layer_accel_octo_datain_router_if
    import cnn_layer_accel_router_pkg::*;
#(
    parameter int C_DATA_WIDTH = C_DATA_WIDTH_DEF,
    parameter int C_SEQ_CNT_W  = C_SEQ_CNT_W_DEF,
    parameter int C_PIX_CNT_W  = C_PIX_CNT_W_DEF
);

    logic                    start;
    logic [C_SEQ_CNT_W-1:0]  cfg_seq_words;
    logic [C_PIX_CNT_W-1:0]  cfg_pix_words;
    logic                    s_valid;
    logic [C_DATA_WIDTH-1:0] s_data;
    logic                    s_ready;
    logic                    new_map;
    logic                    datain_valid;
    logic [C_DATA_WIDTH-1:0] datain;
    logic                    seq_datain_tag;
    logic                    pixel_datain_tag;
    logic                    seq_datain_rdy;
    logic                    pixel_datain_rdy;
    logic                    busy;
    logic                    map_done;
    logic                    proto_err;

    modport master (
        output start, cfg_seq_words, cfg_pix_words, s_valid, s_data,
               seq_datain_rdy, pixel_datain_rdy,
        input  s_ready, new_map, datain_valid, datain, seq_datain_tag,
               pixel_datain_tag, busy, map_done, proto_err
    );

    modport slave (
        input  start, cfg_seq_words, cfg_pix_words, s_valid, s_data,
               seq_datain_rdy, pixel_datain_rdy,
        output s_ready, new_map, datain_valid, datain, seq_datain_tag,
               pixel_datain_tag, busy, map_done, proto_err
    );

endinterface

// File: rtl/cnn_layer_accel_skid_fifo2.sv
// Two-entry register FIFO; head is visible the cycle after the first push (1-cycle latency).
// Push is refused when full unless a pop happens in the same cycle.
module cnn_layer_accel_skid_fifo2
    import cnn_layer_accel_router_pkg::*;
#(
    parameter int C_DATA_WIDTH = C_DATA_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [C_DATA_WIDTH-1:0] push_data,
    input  logic                    pop,
    output logic [C_DATA_WIDTH-1:0] head,
    output logic                    full,
    output logic                    empty
);

    logic [C_DATA_WIDTH-1:0] mem [2];
    logic                    wr_ptr;
    logic                    rd_ptr;
    logic [1:0]              count;
    logic                    do_push;
    logic                    do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/cnn_layer_accel_octo_datain_router.sv
// Splits each map of the input stream into a sequencer phase then a pixel phase for the octo controller.
// Accept-to-datain latency 1 cycle; upstream stalls when the 2-entry FIFO is full or the map total is reached.
module cnn_layer_accel_octo_datain_router
    import cnn_layer_accel_router_pkg::*;
#(
    parameter int C_DATA_WIDTH = C_DATA_WIDTH_DEF,
    parameter int C_SEQ_CNT_W  = C_SEQ_CNT_W_DEF,
    parameter int C_PIX_CNT_W  = C_PIX_CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    cnn_layer_accel_octo_datain_router_if.slave io
);

    state_t                  state;
    state_t                  state_nxt;
    logic [C_SEQ_CNT_W-1:0]  seq_rem;
    logic [C_PIX_CNT_W-1:0]  pix_rem;
    logic [C_PIX_CNT_W:0]    accept_cnt;
    logic [C_PIX_CNT_W:0]    total;
    logic [C_DATA_WIDTH-1:0] head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    in_seq;
    logic                    in_pix;
    logic                    phase_left;
    logic                    datain_valid;
    logic                    seq_pop;
    logic                    pix_pop;
    logic                    push;
    logic                    proto_hit;
    logic                    proto_err;

    assign in_seq       = (state == ST_SEQ);
    assign in_pix       = (state == ST_PIX);
    assign phase_left   = (in_seq && (seq_rem != '0)) || (in_pix && (pix_rem != '0));
    assign datain_valid = !fifo_empty && phase_left;
    assign seq_pop      = datain_valid && in_seq && io.seq_datain_rdy;
    assign pix_pop      = datain_valid && in_pix && io.pixel_datain_rdy;

    assign io.s_ready          = !fifo_full && (in_seq || in_pix) && (accept_cnt < total);
    assign push                = io.s_valid && io.s_ready;
    assign io.datain_valid     = datain_valid;
    assign io.datain           = head;
    assign io.seq_datain_tag   = datain_valid && in_seq;
    assign io.pixel_datain_tag = datain_valid && in_pix;
    assign io.new_map          = (state == ST_NEW_MAP);
    assign io.map_done         = (state == ST_DONE);
    assign io.busy             = (state != ST_IDLE);
    assign io.proto_err        = proto_err;

    // Cross-phase rdy only counts as an error while a word is actually on offer.
    assign proto_hit = (io.seq_datain_rdy && io.pixel_datain_rdy) ||
                       (datain_valid && ((in_seq && io.pixel_datain_rdy) ||
                                         (in_pix && io.seq_datain_rdy)));

    cnn_layer_accel_skid_fifo2 #(
        .C_DATA_WIDTH (C_DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (io.s_data),
        .pop       (seq_pop || pix_pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (io.start) state_nxt = ST_NEW_MAP;
            end
            ST_NEW_MAP: begin
                if (seq_rem != '0)      state_nxt = ST_SEQ;
                else if (pix_rem != '0) state_nxt = ST_PIX;
                else                    state_nxt = ST_DONE;
            end
            ST_SEQ: begin
                if (seq_pop && (seq_rem == C_SEQ_CNT_W'(1)))
                    state_nxt = (pix_rem != '0) ? ST_PIX : ST_DONE;
            end
            ST_PIX: begin
                if (pix_pop && (pix_rem == C_PIX_CNT_W'(1))) state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seq_rem    <= '0;
            pix_rem    <= '0;
            accept_cnt <= '0;
            total      <= '0;
            proto_err  <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && io.start) begin
                seq_rem    <= io.cfg_seq_words;
                pix_rem    <= io.cfg_pix_words;
                total      <= (C_PIX_CNT_W+1)'(io.cfg_seq_words) + (C_PIX_CNT_W+1)'(io.cfg_pix_words);
                accept_cnt <= '0;
            end else begin
                if (push)    accept_cnt <= accept_cnt + 1'b1;
                if (seq_pop) seq_rem    <= seq_rem - 1'b1;
                if (pix_pop) pix_rem    <= pix_rem - 1'b1;
            end
            if (proto_hit) proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cnn_layer_accel_octo_datain_router.sv
// Directed + randomized bench for the octo datain router; reference model is an ordered
// queue of expected (word, phase) pairs built from the map configuration.
module tb_cnn_layer_accel_octo_datain_router;

    localparam int DW = 16;
    localparam int SW = 12;
    localparam int PW = 18;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cnn_layer_accel_octo_datain_router_if #(
        .C_DATA_WIDTH (DW), .C_SEQ_CNT_W (SW), .C_PIX_CNT_W (PW)
    ) bus ();

    cnn_layer_accel_octo_datain_router #(
        .C_DATA_WIDTH (DW), .C_SEQ_CNT_W (SW), .C_PIX_CNT_W (PW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          is_seq;
    } word_t;

    word_t exp_q[$];
    int    n_chk  = 0;
    int    n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.start            = 1'b0;
        bus.cfg_seq_words    = '0;
        bus.cfg_pix_words    = '0;
        bus.s_valid          = 1'b0;
        bus.s_data           = '0;
        bus.seq_datain_rdy   = 1'b0;
        bus.pixel_datain_rdy = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".s_ready"},   32'(bus.s_ready),          32'd0);
        chk({tag, ".new_map"},   32'(bus.new_map),          32'd0);
        chk({tag, ".valid"},     32'(bus.datain_valid),     32'd0);
        chk({tag, ".datain"},    32'(bus.datain),           32'd0);
        chk({tag, ".seq_tag"},   32'(bus.seq_datain_tag),   32'd0);
        chk({tag, ".pix_tag"},   32'(bus.pixel_datain_tag), 32'd0);
        chk({tag, ".busy"},      32'(bus.busy),             32'd0);
        chk({tag, ".map_done"},  32'(bus.map_done),         32'd0);
        chk({tag, ".proto_err"}, 32'(bus.proto_err),        32'd0);
    endtask

    // Controller model: rdy answers the tag seen one cycle earlier, and drops once its phase is exhausted.
    task automatic run_map(input int nseq, input int npix, input logic [DW-1:0] base,
                           input int vpct, input int rpct, input int hold, input int stall_fill);
        int sent = 0, seq_left = nseq, pix_left = npix, total = nseq + npix;
        int nm = 0, md = 0, nm_cyc = -1, md_cyc = -1;
        bit prev_st = 0, prev_pt = 0, seq_tag_seen = 0, sready_seen = 0;
        exp_q.delete();
        for (int i = 0; i < total; i++) exp_q.push_back('{data: base + DW'(i), is_seq: (i < nseq)});
        for (int cyc = 0; cyc < 600 && md == 0; cyc++) begin
            @(posedge clk); #1;
            bus.start            = (cyc == 0);
            bus.cfg_seq_words    = SW'(nseq);
            bus.cfg_pix_words    = PW'(npix);
            bus.s_valid          = (sent < total) && (int'($urandom_range(99)) < vpct);
            bus.s_data           = base + DW'(sent);
            bus.seq_datain_rdy   = prev_st && (seq_left > 0) && (cyc >= hold) && (int'($urandom_range(99)) < rpct);
            bus.pixel_datain_rdy = prev_pt && (pix_left > 0) && (cyc >= hold) && (int'($urandom_range(99)) < rpct);
            #1;
            if (bus.new_map)  begin nm++; nm_cyc = cyc; end
            if (bus.map_done) begin md++; md_cyc = cyc; end
            if (bus.seq_datain_tag) seq_tag_seen = 1;
            if (bus.s_ready) sready_seen = 1;
            if (sent == total) chk("sready_after_total", 32'(bus.s_ready), 32'd0);
            if (hold > 0 && cyc == hold - 1) begin
                chk("stall_fill",   32'(sent),        32'(stall_fill));
                chk("stall_sready", 32'(bus.s_ready), 32'd0);
            end
            if (!bus.datain_valid)
                chk("tags_idle", 32'({bus.seq_datain_tag, bus.pixel_datain_tag}), 32'd0);
            if (bus.datain_valid) begin
                if (exp_q.size() == 0) begin
                    chk("extra_word", 32'(exp_q.size()), 32'd1);
                end else begin
                    chk("head_data", 32'(bus.datain), 32'(exp_q[0].data));
                    chk("head_tag", 32'({bus.seq_datain_tag, bus.pixel_datain_tag}),
                        exp_q[0].is_seq ? 32'd2 : 32'd1);
                    if ((bus.seq_datain_tag && bus.seq_datain_rdy) ||
                        (bus.pixel_datain_tag && bus.pixel_datain_rdy)) begin
                        if (exp_q[0].is_seq) seq_left--; else pix_left--;
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (bus.s_valid && bus.s_ready) sent++;
            prev_st = bus.seq_datain_tag;
            prev_pt = bus.pixel_datain_tag;
        end
        chk("new_map_count",  32'(nm),            32'd1);
        chk("map_done_count", 32'(md),            32'd1);
        chk("all_delivered",  32'(exp_q.size()),  32'd0);
        chk("accepted",       32'(sent),          32'(total));
        chk("proto_clean",    32'(bus.proto_err), 32'd0);
        if (nseq == 0) chk("no_seq_tag", 32'(seq_tag_seen), 32'd0);
        if (total == 0) begin
            chk("done_after_new_map", 32'(md_cyc), 32'(nm_cyc + 1));
            chk("sready_never",       32'(sready_seen), 32'd0);
        end
        @(posedge clk); #1;
        idle_inputs();
        #1;
        chk("busy_after_map", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        idle_inputs();
        #12;
        check_zero("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        // Main case: full-rate stream, rdy one cycle behind valid.
        run_map(3, 4, 16'h0010, 100, 100, 0, 0);
        run_map(0, 2, 16'h0020, 60, 70, 0, 0);
        run_map(0, 0, 16'h0030, 100, 100, 0, 0);
        // Pixel rdy held off: FIFO holds two words and the head stays put.
        run_map(0, 5, 16'h0040, 100, 100, 10, 2);
        for (int m = 0; m < 4; m++)
            run_map(int'($urandom_range(6)), int'($urandom_range(8)), DW'(16'h0100 * (m + 1)),
                    30 + int'($urandom_range(70)), 30 + int'($urandom_range(70)), 0, 0);

        // Protocol error: stale rdy alone is harmless, both rdys together is sticky.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.cfg_seq_words = SW'(2); bus.cfg_pix_words = '0;
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk); #1;
        bus.seq_datain_rdy = 1'b1;
        @(posedge clk); #1;
        bus.seq_datain_rdy = 1'b0;
        #1;
        chk("stale_rdy_no_err", 32'(bus.proto_err), 32'd0);
        bus.seq_datain_rdy = 1'b1; bus.pixel_datain_rdy = 1'b1;
        @(posedge clk); #1;
        idle_inputs();
        #1;
        chk("dual_rdy_err", 32'(bus.proto_err), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("proto_err_sticky", 32'(bus.proto_err), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("proto_err_cleared", 32'(bus.proto_err), 32'd0);

        // Asynchronous reset in the pixel phase with one word buffered.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.cfg_seq_words = '0; bus.cfg_pix_words = PW'(3);
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk); #1;
        bus.s_valid = 1'b1; bus.s_data = 16'h0050;
        #1;
        chk("rst_pre_sready", 32'(bus.s_ready), 32'd1);
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        #1;
        chk("rst_pre_valid",  32'(bus.datain_valid), 32'd1);
        chk("rst_pre_datain", 32'(bus.datain), 32'h0050);
        #2;
        rst = 1'b0;
        #1;
        check_zero("async_rst");
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("abort_no_done",  32'(bus.map_done),     32'd0);
            chk("abort_idle",     32'(bus.busy),         32'd0);
            chk("abort_fifo_empty", 32'(bus.datain_valid), 32'd0);
        end
        run_map(1, 2, 16'h0060, 100, 100, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
